// File: rtl/reg_ctx_seq.sv
// Register-context sequencer: walks every general-purpose register once and
// either saves it to data memory or restores it from data memory, one register
// per cycle. Outside a transfer the core's register-file ports pass straight through.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | forward core rf ports, wait for start
// ST_SAVE    | rf[idx] -> mem[base+idx], one register per cycle, core stalled
// ST_RESTORE | mem[base+idx] -> rf[idx], one register per cycle, core stalled
// ST_DONE    | one-cycle done pulse, core ports forwarded again
module reg_ctx_seq #(
   parameter int dw = 8,
   parameter int pw = 2,
   parameter int aw = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op,
   input  logic [aw-1:0] base_addr,
   output logic          busy,
   output logic          done,
   input  logic [pw-1:0] core_rd_addr,
   input  logic          core_wr_en,
   input  logic [pw-1:0] core_wr_addr,
   input  logic [dw-1:0] core_wr_dat,
   output logic [pw-1:0] rf_rd_addr,
   input  logic [dw-1:0] rf_rd_dat,
   output logic          rf_wr_en,
   output logic [pw-1:0] rf_wr_addr,
   output logic [dw-1:0] rf_wr_dat,
   output logic [aw-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [dw-1:0] mem_wr_dat,
   input  logic [dw-1:0] mem_rd_dat
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [pw-1:0] IDX_LAST = {pw{1'b1}};

   state_t        state_q, state_d;
   logic [pw-1:0] idx_q, idx_d;
   logic          op_q, op_d;
   logic [aw-1:0] base_q, base_d;
   logic [aw-1:0] xfer_addr;

   // idx is zero-extended; the sum wraps modulo 2**aw
   assign xfer_addr = base_q + aw'(idx_q);

   // state, index and latched command registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         op_q    <= 1'b0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         base_q  <= base_d;
      end
   end

   // next-state decode and port muxing between core forwarding and transfers
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      op_d       = op_q;
      base_d     = base_q;
      busy       = 1'b0;
      done       = 1'b0;
      rf_rd_addr = core_rd_addr;
      rf_wr_en   = core_wr_en;
      rf_wr_addr = core_wr_addr;
      rf_wr_dat  = core_wr_dat;
      mem_addr   = base_q;
      mem_wr_en  = 1'b0;
      mem_wr_dat = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op;
               base_d  = base_addr;
               idx_d   = '0;
               state_d = op ? ST_RESTORE : ST_SAVE;
            end
         end

         ST_SAVE, ST_RESTORE: begin
            busy     = 1'b1;
            mem_addr = xfer_addr;
            // core requests are dropped, not queued, while the walk owns the ports
            if (!op_q) begin
               rf_rd_addr = idx_q;
               rf_wr_en   = 1'b0;
               mem_wr_en  = 1'b1;
               mem_wr_dat = rf_rd_dat;
            end else begin
               rf_wr_en   = 1'b1;
               rf_wr_addr = idx_q;
               rf_wr_dat  = mem_rd_dat;
            end
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_ctx_seq.sv
// Directed bench for reg_ctx_seq with a small register file and data memory
// attached to its initiator ports.
module tb_reg_ctx_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic       op;
   logic [7:0] base_addr;
   logic       busy;
   logic       done;
   logic [1:0] core_rd_addr;
   logic       core_wr_en;
   logic [1:0] core_wr_addr;
   logic [7:0] core_wr_dat;
   logic [1:0] rf_rd_addr;
   logic [7:0] rf_rd_dat;
   logic       rf_wr_en;
   logic [1:0] rf_wr_addr;
   logic [7:0] rf_wr_dat;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_wr_dat;
   logic [7:0] mem_rd_dat;

   logic [7:0] rf  [4];
   logic [7:0] mem [256];
   logic       tb_we;
   logic [7:0] tb_addr;
   logic [7:0] tb_dat;

   int pass_cnt = 0;
   int total    = 0;

   reg_ctx_seq #(.dw(8), .pw(2), .aw(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .base_addr    (base_addr),
      .busy         (busy),
      .done         (done),
      .core_rd_addr (core_rd_addr),
      .core_wr_en   (core_wr_en),
      .core_wr_addr (core_wr_addr),
      .core_wr_dat  (core_wr_dat),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_dat    (rf_rd_dat),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_dat    (rf_wr_dat),
      .mem_addr     (mem_addr),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_dat   (mem_wr_dat),
      .mem_rd_dat   (mem_rd_dat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign rf_rd_dat  = rf[rf_rd_addr];
   assign mem_rd_dat = mem[mem_addr];

   // register file and memory: asynchronous read, synchronous write
   always @(posedge clk) begin
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_dat;
      if (mem_wr_en) mem[mem_addr] <= mem_wr_dat;
      else if (tb_we) mem[tb_addr] <= tb_dat;
   end

   task automatic mem_poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_addr = a; tb_dat = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic core_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      core_wr_en = 1'b1; core_wr_addr = a; core_wr_dat = d;
      @(negedge clk);
      core_wr_en = 1'b0;
   endtask

   // issue one command and observe 12 cycles; optional stray starts / core writes
   task automatic run_cmd(input logic o, input logic [7:0] b, input bit ign, input bit blk,
                          output int nbusy, output int ndone, output int done_at,
                          output logic [7:0] addr2);
      @(negedge clk);
      start = 1'b1; op = o; base_addr = b;
      nbusy = 0; ndone = 0; done_at = -1; addr2 = 8'h00;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy === 1'b1) nbusy++;
         if (done === 1'b1) begin
            ndone++;
            if (done_at < 0) done_at = i;
         end
         if (i == 2) addr2 = mem_addr;
         start = ign && (i == 1 || done === 1'b1);
         if (ign) begin op = 1'b1; base_addr = 8'hC0; end
         core_wr_en = blk && (busy === 1'b1);
         if (blk) begin core_wr_addr = 2'd1; core_wr_dat = 8'h55; end
      end
      start = 1'b0; core_wr_en = 1'b0;
   endtask

   task automatic test_reset;
      int seen;
      reset = 1'b1; start = 1'b1; op = 1'b0; base_addr = 8'h33;
      core_rd_addr = 2'd3; core_wr_en = 1'b0; core_wr_addr = 2'd0; core_wr_dat = 8'h00;
      tb_we = 1'b0; tb_addr = 8'h00; tb_dat = 8'h00;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, mem_wr_en} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, mem_wr_en});
      else pass_cnt++;
      total++;
      if (rf_rd_addr !== 2'd3) $display("FAIL reset_rd_fwd got %h want 3", rf_rd_addr);
      else pass_cnt++;
      total++;
      if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got %h want 00", mem_addr);
      else pass_cnt++;
      start = 1'b0; reset = 1'b0;

      core_write(2'd0, 8'h11);
      core_write(2'd1, 8'h22);
      core_write(2'd2, 8'h33);
      core_write(2'd3, 8'h44);
      total++;
      if ({rf[0], rf[1], rf[2], rf[3]} !== 32'h11223344)
         $display("FAIL idle_core_write got %h want 11223344", {rf[0], rf[1], rf[2], rf[3]});
      else pass_cnt++;

      mem_poke(8'h20, 8'h00);
      mem_poke(8'h21, 8'h00);
      mem_poke(8'h22, 8'h00);
      mem_poke(8'h23, 8'h00);
      @(negedge clk);
      start = 1'b1; op = 1'b0; base_addr = 8'h20;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b1) $display("FAIL abort_pre_busy got %b want 1", busy);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      total++;
      if ({busy, done, mem_wr_en} !== 3'b000) $display("FAIL abort_flags got %b want 000", {busy, done, mem_wr_en});
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL abort_no_done got %0d want 0", seen);
      else pass_cnt++;
      total++;
      if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h11220000)
         $display("FAIL abort_mem got %h want 11220000", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]});
      else pass_cnt++;
   endtask

   task automatic test_save;
      int nb, nd, da;
      logic [7:0] a2;
      run_cmd(1'b0, 8'h40, 1'b0, 1'b0, nb, nd, da, a2);
      total++;
      if (nb !== 4 || nd !== 1 || da !== 4) $display("FAIL save_timing got busy=%0d done=%0d at=%0d want 4 1 4", nb, nd, da);
      else pass_cnt++;
      total++;
      if (a2 !== 8'h42) $display("FAIL save_addr got %h want 42", a2);
      else pass_cnt++;
      total++;
      if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'h11223344)
         $display("FAIL save_mem got %h want 11223344", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
      else pass_cnt++;
   endtask

   task automatic test_restore;
      int nb, nd, da;
      logic [7:0] a2;
      mem_poke(8'h80, 8'hA1);
      mem_poke(8'h81, 8'hB2);
      mem_poke(8'h82, 8'hC3);
      mem_poke(8'h83, 8'hD4);
      run_cmd(1'b1, 8'h80, 1'b0, 1'b0, nb, nd, da, a2);
      total++;
      if (nb !== 4 || nd !== 1 || da !== 4) $display("FAIL restore_timing got busy=%0d done=%0d at=%0d want 4 1 4", nb, nd, da);
      else pass_cnt++;
      total++;
      if ({rf[0], rf[1], rf[2], rf[3]} !== 32'hA1B2C3D4)
         $display("FAIL restore_regs got %h want a1b2c3d4", {rf[0], rf[1], rf[2], rf[3]});
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      int nb, nd, da;
      logic [7:0] a2;
      mem_poke(8'hFD, 8'h00);
      mem_poke(8'h02, 8'h00);
      run_cmd(1'b0, 8'hFE, 1'b0, 1'b0, nb, nd, da, a2);
      total++;
      if (a2 !== 8'h00) $display("FAIL wrap_addr got %h want 00", a2);
      else pass_cnt++;
      total++;
      if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'hA1B2C3D4)
         $display("FAIL wrap_mem got %h want a1b2c3d4", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]});
      else pass_cnt++;
      total++;
      if ({mem[8'hFD], mem[8'h02]} !== 16'h0000)
         $display("FAIL wrap_neighbors got %h want 0000", {mem[8'hFD], mem[8'h02]});
      else pass_cnt++;
   endtask

   task automatic test_core_block;
      int nb, nd, da;
      logic [7:0] a2;
      mem_poke(8'h90, 8'h10);
      mem_poke(8'h91, 8'h20);
      mem_poke(8'h92, 8'h30);
      mem_poke(8'h93, 8'h40);
      run_cmd(1'b1, 8'h90, 1'b0, 1'b1, nb, nd, da, a2);
      total++;
      if ({rf[0], rf[1], rf[2], rf[3]} !== 32'h10203040)
         $display("FAIL block_regs got %h want 10203040", {rf[0], rf[1], rf[2], rf[3]});
      else pass_cnt++;
      core_write(2'd1, 8'h55);
      total++;
      if (rf[1] !== 8'h55) $display("FAIL block_idle_write got %h want 55", rf[1]);
      else pass_cnt++;
   endtask

   task automatic test_ignored_start;
      int nb, nd, da;
      logic [7:0] a2;
      mem_poke(8'hC0, 8'hEE);
      mem_poke(8'hC1, 8'hEE);
      mem_poke(8'hC2, 8'hEE);
      mem_poke(8'hC3, 8'hEE);
      run_cmd(1'b0, 8'h60, 1'b1, 1'b0, nb, nd, da, a2);
      total++;
      if (nb !== 4 || nd !== 1) $display("FAIL ignore_timing got busy=%0d done=%0d want 4 1", nb, nd);
      else pass_cnt++;
      total++;
      if ({mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]} !== 32'h10553040)
         $display("FAIL ignore_mem got %h want 10553040", {mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]});
      else pass_cnt++;
      total++;
      if ({rf[0], rf[1], rf[2], rf[3]} !== 32'h10553040)
         $display("FAIL ignore_regs got %h want 10553040", {rf[0], rf[1], rf[2], rf[3]});
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_save;
      test_restore;
      test_wrap;
      test_core_block;
      test_ignored_start;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/reg_ctx_seq.md
# reg_ctx_seq

Register-context sequencer for the 8-bit core: on command it walks all general-purpose registers and either saves them to data memory or restores them from data memory, one register per cycle. It is the initiator side of the register file's ports: in normal operation it forwards the core's register-file read/write signals, and while a save or restore runs it takes ownership of the register-file and data-memory ports. Used for interrupt entry/exit and task switches.

## Interface
- dw, 8, register/data width
- pw, 2, register address width; number of registers N = 2**pw
- aw, 8, data-memory address width

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- op  in  1  0 = save (regs -> mem), 1 = restore (mem -> regs); latched with start
- base_addr  in  aw  memory address for register 0; latched with start
- busy  out  1  high while transfers run; core must stall
- done  out  1  one-cycle pulse after last transfer
- core_rd_addr  in  pw  core register read address (forwarded when not busy)
- core_wr_en  in  1  core register write enable (forwarded when not busy)
- core_wr_addr  in  pw  core register write address
- core_wr_dat  in  dw  core register write data
- rf_rd_addr  out  pw  to register file read address A
- rf_rd_dat  in  dw  from register file output A (asynchronous read)
- rf_wr_en  out  1  to register file write enable
- rf_wr_addr  out  pw  to register file write address
- rf_wr_dat  out  dw  to register file write data
- mem_addr  out  aw  data-memory address
- mem_wr_en  out  1  data-memory write enable (synchronous write)
- mem_wr_dat  out  dw  data-memory write data
- mem_rd_dat  in  dw  data-memory read data (asynchronous read)

## Operation
- States: IDLE, SAVE, RESTORE, DONE. Index counter idx, pw bits. Latched op_q, base_q.
- IDLE: rf_* outputs forward core_* combinationally; mem_wr_en=0, mem_addr=base_q, mem_wr_dat=0. start=1 -> latch op, base_addr; idx<=0; go SAVE (op=0) or RESTORE (op=1).
- SAVE, per cycle: rf_rd_addr=idx, mem_addr=base_q+idx, mem_wr_dat=rf_rd_dat, mem_wr_en=1, rf_wr_en=0.
- RESTORE, per cycle: mem_addr=base_q+idx, rf_wr_en=1, rf_wr_addr=idx, rf_wr_dat=mem_rd_dat, mem_wr_en=0, rf_rd_addr=core_rd_addr.
- In SAVE/RESTORE: idx==N-1 -> DONE, else idx<=idx+1.
- DONE: done=1, busy=0, ports forward core as in IDLE; next state IDLE unconditionally.
- busy=1 exactly in SAVE and RESTORE. Core write/read requests during busy are ignored (not queued).
- Address arithmetic: base_q+idx, zero-extended idx, truncated to aw bits (wraps mod 2**aw).
- start in SAVE/RESTORE/DONE ignored; op/base_addr changes after latch have no effect.

## Timing
- Reset (asynchronous, immediate): state=IDLE, idx=0, op_q=0, base_q=0, busy=0, done=0, mem_wr_en=0; rf_* follow core_* forwarding.
- start high at edge E0 -> busy high after E0 for N cycles (edges E1..EN perform the N writes) -> done high for cycle after EN -> IDLE after EN+1. N=4: start-to-done latency 4 cycles, done in cycle 5.
- Register write (restore) and memory write (save) commit on the edge closing each busy cycle.
- Reset mid-operation: abort immediately to IDLE; already-committed transfers remain; no done pulse.
- reset and start together: reset wins.
- Back-to-back: new start accepted earliest in IDLE cycle after DONE.

## Test plan
- Reset: assert reset mid-SAVE at idx=2 -> busy=0, done=0, mem_wr_en=0 immediately; mem holds only regs 0,1.
- Save: regs {11,22,33,44}, base_addr=8'h40, op=0 -> mem[40..43]={11,22,33,44}, busy 4 cycles, done 1 cycle.
- Restore: mem[80..83]={A1,B2,C3,D4}, op=1, base_addr=8'h80 -> regs {A1,B2,C3,D4}, done one cycle after last write.
- Wrap: base_addr=8'hFE, save -> writes at FE, FF, 00, 01.
- Core blocking: core_wr_en=1 to r1 with 8'h55 during restore -> r1 holds restored value, not 55; same write in IDLE -> r1=55 next edge.
- Ignored start: pulse start with op=1 during active save and during DONE -> single save completes, no restore, exactly one done pulse.
